// File: rtl/delta_decode.sv
// rtl/delta_decode.sv - delta-modulation decoder with slope-overload detection
//
// Purpose:
//   Rebuilds 8-bit unsigned samples from a 1-bit delta-modulated stream.
//   A 10-bit signed integrator moves by +/-STEP per bit and saturates at +511/-512.
//   Its value, clamped to 0..255, is the output sample. A run counter and a small
//   FSM raise 'overload' after RUN_LEN identical bits in a row.
//
// Optional feature (macro MOVAVG_EN):
//   Adds a 4-deep moving average over the clamped samples. sample_valid latency
//   becomes 2 clocks. Overload timing does not change.
//
// Ports:
//   CLK100MHZ     in   1  system clock, all state on rising edge
//   reset         in   1  asynchronous, active-high reset
//   bit_in        in   1  encoded bit (1 = up step, 0 = down step)
//   bit_valid     in   1  bit_in qualifier, one bit consumed per high cycle
//   sync_clear    in   1  synchronous integrator/FSM clear; takes priority over bit_valid
//   sample        out  8  reconstructed sample, unsigned, held between strobes
//   sample_valid  out  1  one-cycle strobe, sample updated
//   overload      out  1  slope-overload flag, level

module delta_decode #(
  parameter int STEP    = 20,
  parameter int RUN_LEN = 8
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       sync_clear,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       overload
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    OVERLOAD = 2'd2
  } state_t;

  localparam logic signed [11:0] STEP_W  = 12'(STEP);
  localparam logic        [3:0]  RUN_MAX = 4'(RUN_LEN);

  state_t state, state_next;

  logic signed [9:0]  acc;
  logic signed [9:0]  acc_step;
  logic signed [11:0] acc_ext;
  logic signed [11:0] acc_sum;
  logic        [7:0]  clamped;
  logic        [3:0]  run, run_next;
  logic               prev_bit, prev_bit_next;
  logic               overload_next;
  logic               take;

  // sync_clear wins over bit_valid: the bit is dropped entirely.
  assign take = bit_valid & ~sync_clear;

  // Integrator step, computed 2 bits wider so the saturation test cannot wrap.
  always_comb begin
    acc_ext = {{2{acc[9]}}, acc};
    acc_sum = bit_in ? (acc_ext + STEP_W) : (acc_ext - STEP_W);
    if (acc_sum > 12'sd511) begin
      acc_step = 10'sd511;
    end else if (acc_sum < -12'sd512) begin
      acc_step = -10'sd512;
    end else begin
      acc_step = acc_sum[9:0];
    end
  end

  // Clamp the new integrator value to the unsigned 8-bit output range.
  always_comb begin
    if (acc_step[9]) begin
      clamped = 8'd0;
    end else if (acc_step > 10'sd255) begin
      clamped = 8'hFF;
    end else begin
      clamped = acc_step[7:0];
    end
  end

  // Run counter and overload FSM, next-state logic.
  always_comb begin
    state_next    = state;
    run_next      = run;
    prev_bit_next = prev_bit;
    overload_next = overload;
    if (sync_clear) begin
      state_next    = IDLE;
      run_next      = 4'd0;
      overload_next = 1'b0;
    end else if (bit_valid) begin
      prev_bit_next = bit_in;
      // In IDLE prev_bit is stale, so the first bit always starts a fresh run.
      if (state == IDLE || bit_in != prev_bit) begin
        run_next = 4'd1;
      end else if (run < RUN_MAX) begin
        run_next = run + 4'd1;
      end
      case (state)
        IDLE: begin
          state_next = TRACK;
        end
        TRACK: begin
          if (run_next == RUN_MAX) begin
            state_next    = OVERLOAD;
            overload_next = 1'b1;
          end
        end
        OVERLOAD: begin
          if (bit_in != prev_bit) begin
            state_next    = TRACK;
            overload_next = 1'b0;
          end
        end
        default: begin
          state_next    = IDLE;
          overload_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      run      <= 4'd0;
      prev_bit <= 1'b0;
      overload <= 1'b0;
      acc      <= 10'sd0;
    end else begin
      state    <= state_next;
      run      <= run_next;
      prev_bit <= prev_bit_next;
      overload <= overload_next;
      if (sync_clear) begin
        acc <= 10'sd0;
      end else if (bit_valid) begin
        acc <= acc_step;
      end
    end
  end

`ifdef MOVAVG_EN
  // h0 is the newest clamped sample. The average is taken one cycle after the
  // history update, which gives the 2-clock strobe latency.
  logic [7:0] h0, h1, h2, h3;
  logic       avg_pend;
  logic [9:0] hist_sum;

  assign hist_sum = {2'b00, h0} + {2'b00, h1} + {2'b00, h2} + {2'b00, h3};

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      h0           <= 8'd0;
      h1           <= 8'd0;
      h2           <= 8'd0;
      h3           <= 8'd0;
      avg_pend     <= 1'b0;
      sample       <= 8'd0;
      sample_valid <= 1'b0;
    end else begin
      avg_pend     <= take;
      sample_valid <= avg_pend;
      if (avg_pend) begin
        sample <= hist_sum[9:2];
      end
      if (sync_clear) begin
        h0 <= 8'd0;
        h1 <= 8'd0;
        h2 <= 8'd0;
        h3 <= 8'd0;
      end else if (bit_valid) begin
        h0 <= clamped;
        h1 <= h0;
        h2 <= h1;
        h3 <= h2;
      end
    end
  end
`else
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sample       <= 8'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= take;
      if (take) begin
        sample <= clamped;
      end
    end
  end
`endif

endmodule

// File: tb/tb_delta_decode.sv
// tb/tb_delta_decode.sv - self-checking bench for delta_decode

module tb_delta_decode;

  localparam int STEP    = 20;
  localparam int RUN_LEN = 8;

  logic       CLK100MHZ  = 1'b0;
  logic       reset      = 1'b1;
  logic       bit_in     = 1'b0;
  logic       bit_valid  = 1'b0;
  logic       sync_clear = 1'b0;
  logic [7:0] sample;
  logic       sample_valid;
  logic       overload;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers, uncapped run length).
  int m_acc;
  int m_run;
  bit m_prev;
  int e_sample;
  bit e_valid;
  bit e_ovl;
`ifdef MOVAVG_EN
  int m_hist[4];
  bit pend_v;
  int pend_val;
`endif

  delta_decode #(.STEP(STEP), .RUN_LEN(RUN_LEN)) dut (
    .CLK100MHZ   (CLK100MHZ),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .sync_clear  (sync_clear),
    .sample      (sample),
    .sample_valid(sample_valid),
    .overload    (overload)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic model_reset();
    m_acc    = 0;
    m_run    = 0;
    m_prev   = 1'b0;
    e_sample = 0;
    e_valid  = 1'b0;
    e_ovl    = 1'b0;
`ifdef MOVAVG_EN
    for (int k = 0; k < 4; k++) m_hist[k] = 0;
    pend_v   = 1'b0;
    pend_val = 0;
`endif
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    bit_valid  = 1'b0;
    sync_clear = 1'b0;
    repeat (2) @(posedge CLK100MHZ);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; afterwards e_* hold what the outputs must show.
  task automatic drive(input bit v, input bit b, input bit c);
    int nv;
    bit nvld;
    bit_valid  = v;
    bit_in     = b;
    sync_clear = c;
    @(posedge CLK100MHZ);
    #1;
    bit_valid  = 1'b0;
    sync_clear = 1'b0;
    nv   = 0;
    nvld = 1'b0;
    if (c) begin
      m_acc = 0;
      m_run = 0;
`ifdef MOVAVG_EN
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
`endif
    end else if (v) begin
      m_acc = m_acc + (b ? STEP : -STEP);
      if (m_acc > 511)  m_acc = 511;
      if (m_acc < -512) m_acc = -512;
      m_run  = (m_run > 0 && b == m_prev) ? m_run + 1 : 1;
      m_prev = b;
      nvld   = 1'b1;
      nv     = (m_acc < 0) ? 0 : ((m_acc > 255) ? 255 : m_acc);
`ifdef MOVAVG_EN
      m_hist[3] = m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = nv;
      nv = (m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3]) / 4;
`endif
    end
    e_ovl = (m_run >= RUN_LEN);
`ifdef MOVAVG_EN
    e_valid = pend_v;
    if (pend_v) e_sample = pend_val;
    pend_v   = nvld;
    pend_val = nv;
`else
    e_valid = nvld;
    if (nvld) e_sample = nv;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge CLK100MHZ);
    #1;
    n_checks++;
    if ({sample_valid, overload, sample} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b o=%0b s=%0d, expected all 0", sample_valid, overload, sample);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp();
    int lit[3];
    lit = '{20, 40, 60};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 1'b1, 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL ramp[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
`ifndef MOVAVG_EN
      if (i < 3) begin
        n_checks++;
        if (sample !== 8'(lit[i]) || sample_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL ramp_literal[%0d]: got s=%0d v=%0b, expected s=%0d v=1", i, sample, sample_valid, lit[i]);
        end
      end
`endif
    end
  endtask

  task automatic test_negative();
    bit bits[3];
    bits = '{1'b0, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, (i < 3) ? bits[i] : 1'b0, 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL negative[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
    end
`ifndef MOVAVG_EN
    n_checks++;
    if (sample !== 8'd20) begin
      n_fail++;
      $display("FAIL negative_literal: got s=%0d, expected s=20", sample);
    end
`endif
  endtask

  task automatic test_overload();
    apply_reset();
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, (i <= 14), 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL overload_seq[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
      n_checks++;
      if (overload !== (i >= 8 && i <= 14)) begin
        n_fail++;
        $display("FAIL overload_flag[%0d]: got %0b, expected %0b", i, overload, (i >= 8 && i <= 14));
      end
    end
`ifndef MOVAVG_EN
    n_checks++;
    if (sample !== 8'd255) begin
      n_fail++;
      $display("FAIL overload_clamp: got s=%0d, expected s=255", sample);
    end
`endif
  endtask

  task automatic test_saturation();
    apply_reset();
    // 30 ones pin the integrator at +511, 60 zeros pin it at -512, then climb back.
    for (int i = 0; i < 120; i++) begin
      drive(1'b1, (i < 30) || (i >= 90), 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
    end
  endtask

  task automatic test_sync_clear();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
      n_fail++;
      $display("FAIL sync_clear_drop: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
               sample_valid, overload, sample, e_valid, e_ovl, e_sample);
    end
`ifndef MOVAVG_EN
    n_checks++;
    if (sample_valid !== 1'b0 || sample !== 8'd60) begin
      n_fail++;
      $display("FAIL sync_clear_hold: got v=%0b s=%0d, expected v=0 s=60", sample_valid, sample);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL sync_clear_restart[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 11; i++) drive(1'b1, (i >= 3), 1'b0);
    n_checks++;
    if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]} || overload !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got v=%0b o=%0b s=%0d, expected v=%0b o=1 s=%0d",
               sample_valid, overload, sample, e_valid, e_sample);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({sample_valid, overload, sample} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset_now: got v=%0b o=%0b s=%0d, expected all 0", sample_valid, overload, sample);
    end
    @(posedge CLK100MHZ);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1'b1, 1'b0);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL async_restart[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
    end
  endtask

`ifdef MOVAVG_EN
  task automatic test_movavg();
    int lit[4];
    lit = '{5, 15, 30, 50};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 1'b1, 1'b0);
      n_checks++;
      if (i == 0 ? (sample_valid !== 1'b0)
                 : (sample_valid !== 1'b1 || sample !== 8'(lit[i-1]))) begin
        n_fail++;
        $display("FAIL movavg[%0d]: got v=%0b s=%0d, expected v=%0b s=%0d",
                 i, sample_valid, sample, (i != 0), (i == 0) ? 0 : lit[i-1]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back_random();
    bit cur;
    bit v;
    bit c;
    apply_reset();
    cur = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 15) cur = ~cur;
      v = ($urandom_range(99) < 80);
      c = ($urandom_range(99) < 3);
      drive(v, cur, c);
      n_checks++;
      if ({sample_valid, overload, sample} !== {e_valid, e_ovl, e_sample[7:0]}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b o=%0b s=%0d, expected v=%0b o=%0b s=%0d",
                 i, sample_valid, overload, sample, e_valid, e_ovl, e_sample);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_negative();
    test_overload();
    test_saturation();
    test_sync_clear();
    test_async_reset();
`ifdef MOVAVG_EN
    test_movavg();
`endif
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
